// File: rtl/match_controller.sv
// Match supervisor: game state, seconds countdown, team scores, bludger penalty
// timers and the end-of-match winner flags.
module match_controller #(
  parameter int TICKS_PER_SEC   = 50000000,
  parameter int MATCH_SECONDS   = 180,
  parameter int TIME_W          = 8,
  parameter int NUM_TEAMS       = 2,
  parameter int SCORE_W         = 7,
  parameter int NUM_PLAYERS     = 4,
  parameter int PENALTY_SECONDS = 5,
  parameter int NUM_BUTTONS     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BUTTONS-1:0]         buttons_n,
  input  logic                           pause_req,
  input  logic                           restart_req,
  input  logic [NUM_TEAMS-1:0]           score_pulse,
  input  logic [NUM_PLAYERS-1:0]         hit_pulse,
  output logic [1:0]                     state,
  output logic [TIME_W-1:0]              time_left,
  output logic                           sec_tick,
  output logic [NUM_TEAMS*SCORE_W-1:0]   scores,
  output logic [NUM_PLAYERS-1:0]         frozen,
  output logic [NUM_PLAYERS*4-1:0]       penalty_left,
  output logic [NUM_TEAMS-1:0]           winner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(MATCH_SECONDS);
  localparam logic [3:0]         PEN_INIT  = 4'(PENALTY_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               cur_state, nxt_state;
  logic [PRE_W-1:0]     prescaler;
  logic                 tick, last_tick;
  logic [SCORE_W-1:0]   max_score;
  logic [NUM_TEAMS-1:0] win_next;

  assign tick      = (cur_state == RUNNING) && (prescaler == PRE_MAX);
  assign last_tick = tick && (time_left == TIME_W'(1));
  assign state     = cur_state;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  // The final tick beats a simultaneous pause request.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (~&buttons_n) nxt_state = RUNNING;
      RUNNING: begin
        if (last_tick)      nxt_state = OVER;
        else if (pause_req) nxt_state = PAUSED;
      end
      PAUSED:  if (pause_req) nxt_state = RUNNING;
      OVER:    if (restart_req) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    max_score = '0;
    win_next  = '0;
    for (int t = 0; t < NUM_TEAMS; t++)
      if (scores[t*SCORE_W +: SCORE_W] > max_score) max_score = scores[t*SCORE_W +: SCORE_W];
    for (int t = 0; t < NUM_TEAMS; t++)
      win_next[t] = (scores[t*SCORE_W +: SCORE_W] == max_score);
  end

  always_comb begin
    frozen = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) frozen[p] = |penalty_left[p*4 +: 4];
  end

  // The pause edge holds the prescaler so a resumed second keeps its remaining
  // counts; a tick already due on that edge still fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      time_left    <= TIME_INIT;
      sec_tick     <= 1'b0;
      scores       <= '0;
      penalty_left <= '0;
      winner       <= '0;
    end else begin
      sec_tick <= tick;
      case (cur_state)
        RUNNING: begin
          if (tick) begin
            prescaler <= '0;
            time_left <= time_left - 1'b1;
          end else if (!pause_req) begin
            prescaler <= prescaler + 1'b1;
          end
          for (int t = 0; t < NUM_TEAMS; t++)
            if (score_pulse[t] && scores[t*SCORE_W +: SCORE_W] != SCORE_MAX)
              scores[t*SCORE_W +: SCORE_W] <= scores[t*SCORE_W +: SCORE_W] + 1'b1;
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (hit_pulse[p] && (penalty_left[p*4 +: 4] == 4'd0 ||
                                 (tick && penalty_left[p*4 +: 4] == 4'd1)))
              penalty_left[p*4 +: 4] <= PEN_INIT;
            else if (tick && penalty_left[p*4 +: 4] != 4'd0)
              penalty_left[p*4 +: 4] <= penalty_left[p*4 +: 4] - 1'b1;
          end
        end
        OVER: begin
          penalty_left <= '0;
          if (restart_req) begin
            prescaler <= '0;
            time_left <= TIME_INIT;
            scores    <= '0;
            winner    <= '0;
          end else begin
            winner <= win_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
